// File: rtl/hpu_ren_rat_ckpt_if.sv
// hpu_ren_rat_ckpt_if: rename group, checkpoint control and flush bundle
// between the decode/branch front end (master) and the rename table (slave).
interface hpu_ren_rat_ckpt_if #(
    parameter int DEC_W  = 2,
    parameter int ARC_N  = 32,
    parameter int PHY_W  = 6,
    parameter int CKPT_N = 4
);
    localparam int AW = $clog2(ARC_N);
    localparam int CW = $clog2(CKPT_N);
    logic                        ren_vld_i;
    logic                        ren_rdy_o;
    logic [DEC_W-1:0][AW-1:0]    arc_rs1_i;
    logic [DEC_W-1:0][AW-1:0]    arc_rs2_i;
    logic [DEC_W-1:0][AW-1:0]    arc_rd_i;
    logic [DEC_W-1:0]            rd_act_i;
    logic [DEC_W-1:0][PHY_W-1:0] phy_rd_i;
    logic [DEC_W-1:0][PHY_W-1:0] phy_rs1_o;
    logic [DEC_W-1:0][PHY_W-1:0] phy_rs2_o;
    logic [DEC_W-1:0][PHY_W-1:0] phy_old_rd_o;
    logic                        ckpt_save_i;
    logic                        ckpt_rdy_o;
    logic [CW-1:0]               ckpt_idx_o;
    logic                        ckpt_rel_i;
    logic                        ckpt_rcov_i;
    logic [CW-1:0]               ckpt_rcov_idx_i;
    logic                        arat_rcov_i;
    logic [ARC_N-1:0][PHY_W-1:0] arat_data_i;
    logic [CW:0]                 ckpt_cnt_o;
    modport master (
        output ren_vld_i, arc_rs1_i, arc_rs2_i, arc_rd_i, rd_act_i, phy_rd_i,
               ckpt_save_i, ckpt_rel_i, ckpt_rcov_i, ckpt_rcov_idx_i, arat_rcov_i, arat_data_i,
        input  ren_rdy_o, phy_rs1_o, phy_rs2_o, phy_old_rd_o, ckpt_rdy_o, ckpt_idx_o, ckpt_cnt_o
    );
    modport slave (
        input  ren_vld_i, arc_rs1_i, arc_rs2_i, arc_rd_i, rd_act_i, phy_rd_i,
               ckpt_save_i, ckpt_rel_i, ckpt_rcov_i, ckpt_rcov_idx_i, arat_rcov_i, arat_data_i,
        output ren_rdy_o, phy_rs1_o, phy_rs2_o, phy_old_rd_o, ckpt_rdy_o, ckpt_idx_o, ckpt_cnt_o
    );
endinterface

// File: rtl/hpu_ren_rat_ckpt.sv
// hpu_ren_rat_ckpt: register alias table with intra-group bypass and a ring of
// branch checkpoints, restorable from a snapshot or from the committed map.
module hpu_ren_rat_ckpt #(
    parameter int DEC_W  = 2,
    parameter int ARC_N  = 32,
    parameter int PHY_W  = 6,
    parameter int CKPT_N = 4
) (
    input logic clk_i,
    input logic rst_i,
    hpu_ren_rat_ckpt_if.slave bus
);
    localparam int AW = $clog2(ARC_N);
    localparam int CW = $clog2(CKPT_N);
    localparam logic [CW:0] FULL = (CW+1)'(CKPT_N);
    typedef enum logic {IDLE, RCOV} state_t;
    typedef logic [ARC_N-1:0][PHY_W-1:0] map_t;
    state_t state;
    map_t rat, rat_nxt, arat_map;
    map_t snap [CKPT_N];
    logic [CW-1:0] head, tail, rcov_span;
    logic [CW:0] cnt;
    logic [DEC_W-1:0][PHY_W-1:0] rs1, rs2, old_rd;
    logic rcov_any, ckpt_rdy, ren_rdy, fire, save_fire, rel_fire;
    assign rcov_any = bus.arat_rcov_i || bus.ckpt_rcov_i;
    assign ckpt_rdy = cnt < FULL;
    assign ren_rdy = state == IDLE && !rcov_any && !(bus.ckpt_save_i && !ckpt_rdy);
    assign fire = bus.ren_vld_i && ren_rdy;
    assign save_fire = fire && bus.ckpt_save_i;
    assign rel_fire = bus.ckpt_rel_i && cnt != '0;
    assign rcov_span = bus.ckpt_rcov_idx_i - head;
    assign bus.ren_rdy_o = ren_rdy;
    assign bus.ckpt_rdy_o = ckpt_rdy;
    assign bus.ckpt_idx_o = tail;
    assign bus.ckpt_cnt_o = cnt;
    assign bus.phy_rs1_o = rs1;
    assign bus.phy_rs2_o = rs2;
    assign bus.phy_old_rd_o = old_rd;
    // Ascending j lets the youngest older slot in the group win the bypass.
    always_comb begin
        for (int i = 0; i < DEC_W; i++) begin
            rs1[i] = rat[bus.arc_rs1_i[i]];
            rs2[i] = rat[bus.arc_rs2_i[i]];
            old_rd[i] = rat[bus.arc_rd_i[i]];
            for (int j = 0; j < i; j++) begin
                if (bus.rd_act_i[j] && bus.arc_rd_i[j] != '0) begin
                    rs1[i] = bus.arc_rd_i[j] == bus.arc_rs1_i[i] ? bus.phy_rd_i[j] : rs1[i];
                    rs2[i] = bus.arc_rd_i[j] == bus.arc_rs2_i[i] ? bus.phy_rd_i[j] : rs2[i];
                    old_rd[i] = bus.arc_rd_i[j] == bus.arc_rd_i[i] ? bus.phy_rd_i[j] : old_rd[i];
                end
            end
        end
    end
    always_comb begin
        rat_nxt = rat;
        for (int i = 0; i < DEC_W; i++)
            if (fire && bus.rd_act_i[i] && bus.arc_rd_i[i] != '0)
                rat_nxt[bus.arc_rd_i[i]] = bus.phy_rd_i[i];
        arat_map = bus.arat_data_i;
        arat_map[0] = '0;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            rat <= '0;
            head <= '0;
            tail <= '0;
            cnt <= '0;
            for (int k = 0; k < CKPT_N; k++) snap[k] <= '0;
        end else begin
            state <= rcov_any ? RCOV : IDLE;
            if (bus.arat_rcov_i) begin
                rat <= arat_map;
                head <= '0;
                tail <= '0;
                cnt <= '0;
            end else if (bus.ckpt_rcov_i) begin
                rat <= snap[bus.ckpt_rcov_idx_i];
                head <= head + CW'(rel_fire);
                tail <= bus.ckpt_rcov_idx_i;
                cnt <= {1'b0, rcov_span} - (CW+1)'(rel_fire);
            end else begin
                rat <= rat_nxt;
                head <= head + CW'(rel_fire);
                tail <= tail + CW'(save_fire);
                cnt <= cnt + (CW+1)'(save_fire) - (CW+1)'(rel_fire);
                if (save_fire) snap[tail] <= rat_nxt;
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (rat[0] == '0);
            assert (cnt <= FULL);
            assert (!(bus.ckpt_rcov_i && !bus.arat_rcov_i && rel_fire && bus.ckpt_rcov_idx_i == head));
            for (int i = 1; i < ARC_N; i++)
                for (int j = i + 1; j < ARC_N; j++)
                    assert (rat[i] == '0 || rat[i] != rat[j]);
        end
    end
endmodule

// File: tb/tb_hpu_ren_rat_ckpt.sv
// tb_hpu_ren_rat_ckpt: directed scenarios then random traffic, all checked
// against a map-plus-checkpoint-queue reference model.
module tb_hpu_ren_rat_ckpt;
    localparam int DEC_W = 2, ARC_N = 32, PHY_W = 6, CKPT_N = 4;
    localparam int AW = $clog2(ARC_N), CW = $clog2(CKPT_N);
    typedef struct packed {
        logic [CW-1:0] idx;
        logic [ARC_N-1:0][PHY_W-1:0] m;
    } ck_t;
    logic clk_i = 0;
    logic rst_i;
    always #5 clk_i = ~clk_i;
    hpu_ren_rat_ckpt_if #(.DEC_W(DEC_W), .ARC_N(ARC_N), .PHY_W(PHY_W), .CKPT_N(CKPT_N)) bus();
    hpu_ren_rat_ckpt #(.DEC_W(DEC_W), .ARC_N(ARC_N), .PHY_W(PHY_W), .CKPT_N(CKPT_N)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus)
    );
    logic [ARC_N-1:0][PHY_W-1:0] m_rat;
    ck_t m_q[$];
    int m_tail;
    bit m_rcov;
    int errs = 0, checks = 0;
    int seq[6] = '{0, 1, 2, 3, 0, 1};
    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    function automatic logic [PHY_W-1:0] look(int slot, logic [AW-1:0] s);
        logic [PHY_W-1:0] r = m_rat[s];
        for (int j = 0; j < slot; j++)
            if (bus.rd_act_i[j] && bus.arc_rd_i[j] == s && s != 0) r = bus.phy_rd_i[j];
        return r;
    endfunction
    task automatic m_reset();
        m_rat = '0;
        m_q.delete();
        m_tail = 0;
        m_rcov = 0;
    endtask
    task automatic idle();
        bus.ren_vld_i = 0;
        bus.arc_rs1_i = '0;
        bus.arc_rs2_i = '0;
        bus.arc_rd_i = '0;
        bus.rd_act_i = '0;
        bus.phy_rd_i = '0;
        bus.ckpt_save_i = 0;
        bus.ckpt_rel_i = 0;
        bus.ckpt_rcov_i = 0;
        bus.ckpt_rcov_idx_i = '0;
        bus.arat_rcov_i = 0;
        bus.arat_data_i = '0;
    endtask
    task automatic step();
        bit rdy;
        ck_t c;
        int pos;
        #1;
        rdy = !m_rcov && !bus.arat_rcov_i && !bus.ckpt_rcov_i && !(bus.ckpt_save_i && m_q.size() == CKPT_N);
        chk("ren_rdy", bus.ren_rdy_o, rdy);
        chk("ckpt_rdy", bus.ckpt_rdy_o, m_q.size() < CKPT_N);
        chk("ckpt_idx", bus.ckpt_idx_o, m_tail);
        chk("ckpt_cnt", bus.ckpt_cnt_o, m_q.size());
        for (int i = 0; i < DEC_W; i++) begin
            chk("phy_rs1", bus.phy_rs1_o[i], look(i, bus.arc_rs1_i[i]));
            chk("phy_rs2", bus.phy_rs2_o[i], look(i, bus.arc_rs2_i[i]));
            chk("phy_old_rd", bus.phy_old_rd_o[i], look(i, bus.arc_rd_i[i]));
        end
        if (rst_i) m_reset();
        else begin
            if (bus.arat_rcov_i) begin
                m_rat = bus.arat_data_i;
                m_rat[0] = '0;
                m_q.delete();
                m_tail = 0;
            end else begin
                if (bus.ckpt_rel_i && m_q.size() > 0) void'(m_q.pop_front());
                if (bus.ckpt_rcov_i) begin
                    pos = -1;
                    foreach (m_q[k]) if (pos < 0 && m_q[k].idx == bus.ckpt_rcov_idx_i) pos = k;
                    if (pos >= 0) begin
                        m_rat = m_q[pos].m;
                        while (m_q.size() > pos) void'(m_q.pop_back());
                    end
                    m_tail = int'(bus.ckpt_rcov_idx_i);
                end else if (bus.ren_vld_i && rdy) begin
                    for (int i = 0; i < DEC_W; i++)
                        if (bus.rd_act_i[i] && bus.arc_rd_i[i] != 0) m_rat[bus.arc_rd_i[i]] = bus.phy_rd_i[i];
                    if (bus.ckpt_save_i) begin
                        c.idx = CW'(m_tail);
                        c.m = m_rat;
                        m_q.push_back(c);
                        m_tail = (m_tail + 1) % CKPT_N;
                    end
                end
            end
            m_rcov = bus.arat_rcov_i || bus.ckpt_rcov_i;
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask
    task automatic rand_drive();
        bit used[64];
        int pool[63];
        int r, t, lo;
        logic [PHY_W-1:0] p;
        bit rel;
        rst_i = $urandom_range(199) == 0;
        bus.ren_vld_i = $urandom_range(3) != 0;
        bus.rd_act_i = DEC_W'($urandom);
        for (int a = 0; a < ARC_N; a++) used[m_rat[a]] = 1;
        used[0] = 1;
        for (int i = 0; i < DEC_W; i++) begin
            bus.arc_rs1_i[i] = AW'($urandom_range(ARC_N - 1));
            bus.arc_rs2_i[i] = AW'($urandom_range(7));
            bus.arc_rd_i[i] = AW'($urandom_range(7));
            do p = PHY_W'($urandom_range(63, 1)); while (used[p]);
            used[p] = 1;
            bus.phy_rd_i[i] = p;
        end
        bus.ckpt_save_i = $urandom_range(2) == 0;
        bus.ckpt_rel_i = $urandom_range(3) == 0;
        bus.arat_rcov_i = $urandom_range(39) == 0;
        rel = bus.ckpt_rel_i && m_q.size() > 0;
        lo = rel ? 1 : 0;
        bus.ckpt_rcov_i = 0;
        bus.ckpt_rcov_idx_i = '0;
        if ($urandom_range(9) == 0 && m_q.size() > lo) begin
            bus.ckpt_rcov_i = 1;
            bus.ckpt_rcov_idx_i = m_q[$urandom_range(m_q.size() - 1, lo)].idx;
        end
        for (int k = 0; k < 63; k++) pool[k] = k + 1;
        for (int k = 62; k > 0; k--) begin
            r = $urandom_range(k);
            t = pool[k];
            pool[k] = pool[r];
            pool[r] = t;
        end
        for (int a = 0; a < ARC_N; a++) bus.arat_data_i[a] = PHY_W'(pool[a]);
    endtask
    initial begin
        idle();
        m_reset();
        rst_i = 1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 0;
        #1;
        chk("rst_ren_rdy", bus.ren_rdy_o, 1);
        chk("rst_ckpt_rdy", bus.ckpt_rdy_o, 1);
        chk("rst_idx", bus.ckpt_idx_o, 0);
        chk("rst_cnt", bus.ckpt_cnt_o, 0);
        step();
        bus.ren_vld_i = 1; bus.rd_act_i = 2'b01; bus.arc_rd_i[0] = 5; bus.phy_rd_i[0] = 10; bus.arc_rs1_i[1] = 5;
        #1 chk("byp_rs1", bus.phy_rs1_o[1], 10);
        step();
        idle();
        bus.ren_vld_i = 1; bus.rd_act_i = 2'b11; bus.arc_rd_i[0] = 7; bus.arc_rd_i[1] = 7;
        bus.phy_rd_i[0] = 3; bus.phy_rd_i[1] = 4; bus.arc_rs1_i[0] = 5;
        #1 chk("rat5", bus.phy_rs1_o[0], 10);
        chk("old_rd_byp", bus.phy_old_rd_o[1], 3);
        step();
        idle(); bus.arc_rs1_i[0] = 7;
        #1 chk("rat7_hi_slot", bus.phy_rs1_o[0], 4);
        step();
        idle(); bus.ren_vld_i = 1; bus.rd_act_i = 2'b01; bus.arc_rd_i[0] = 3; bus.phy_rd_i[0] = 8; bus.ckpt_save_i = 1;
        step();
        idle(); bus.ren_vld_i = 1; bus.rd_act_i = 2'b01; bus.arc_rd_i[0] = 3; bus.phy_rd_i[0] = 9; bus.ckpt_save_i = 1;
        step();
        idle(); bus.arc_rs1_i[0] = 3; bus.ckpt_rcov_i = 1; bus.ckpt_rcov_idx_i = 0;
        #1 chk("rat3_young", bus.phy_rs1_o[0], 9);
        chk("cnt_two", bus.ckpt_cnt_o, 2);
        step();
        idle(); bus.arc_rs1_i[0] = 3; bus.ren_vld_i = 1;
        #1 chk("rcov_stall", bus.ren_rdy_o, 0);
        chk("rat3_restored", bus.phy_rs1_o[0], 8);
        chk("rcov_cnt", bus.ckpt_cnt_o, 0);
        chk("rcov_tail", bus.ckpt_idx_o, 0);
        step();
        idle();
        #1 chk("rcov_done", bus.ren_rdy_o, 1);
        step();
        repeat (4) begin
            idle(); bus.ren_vld_i = 1; bus.ckpt_save_i = 1;
            step();
        end
        idle(); bus.ren_vld_i = 1; bus.ckpt_save_i = 1;
        #1 chk("full_cnt", bus.ckpt_cnt_o, 4);
        chk("full_ckpt_rdy", bus.ckpt_rdy_o, 0);
        chk("full_stall", bus.ren_rdy_o, 0);
        step();
        idle(); bus.ren_vld_i = 1; bus.ckpt_save_i = 1; bus.ckpt_rel_i = 1;
        #1 chk("full_rel_stall", bus.ren_rdy_o, 0);
        step();
        idle();
        #1 chk("rel_cnt", bus.ckpt_cnt_o, 3);
        chk("rel_rdy", bus.ckpt_rdy_o, 1);
        step();
        idle(); bus.arat_rcov_i = 1; bus.ckpt_rcov_i = 1; bus.ckpt_rcov_idx_i = 2;
        for (int a = 0; a < ARC_N; a++) bus.arat_data_i[a] = PHY_W'(a + 32);
        bus.arat_data_i[2] = 12;
        step();
        idle(); bus.arc_rs1_i[0] = 2; bus.arc_rs2_i[0] = 0;
        #1 chk("arat_x2", bus.phy_rs1_o[0], 12);
        chk("arat_x0", bus.phy_rs2_o[0], 0);
        chk("arat_cnt", bus.ckpt_cnt_o, 0);
        step();
        for (int k = 0; k < 6; k++) begin
            idle(); bus.ren_vld_i = 1; bus.ckpt_save_i = 1; bus.ckpt_rel_i = 1;
            #1 chk("wrap_idx", bus.ckpt_idx_o, seq[k]);
            step();
        end
        repeat (3) begin
            idle(); bus.ren_vld_i = 1; bus.ckpt_save_i = 1;
            step();
        end
        idle(); rst_i = 1; bus.ren_vld_i = 1; bus.ckpt_save_i = 1; bus.ckpt_rel_i = 1; bus.arat_rcov_i = 1;
        step();
        idle(); rst_i = 0;
        #1 chk("rst_full_cnt", bus.ckpt_cnt_o, 0);
        chk("rst_full_rdy", bus.ren_rdy_o, 1);
        step();
        repeat (3000) begin
            rand_drive();
            step();
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
